// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin arbiter sharing one registered FIFO write port
//             between NUM_REQ valid/ready producers, with burst holding,
//             per-port enable mask and lookahead FIFO occupancy check.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              port_enable,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [$clog2(FIFO_DEPTH):0]     fifo_entry,
  output logic                            fifo_wr_enb,
  output logic [DATA_WIDTH-1:0]           fifo_wdata,
  output logic [$clog2(NUM_REQ)-1:0]      active_port,
  output logic                            busy
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BEAT_W = 4;

  // GAP is the single dead cycle inserted every time ownership rotates.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [BEAT_W-1:0]   r_beat_cnt;

  logic [NUM_REQ-1:0]    w_elig;
  logic [CNT_W:0]        w_occ;
  logic                  w_room;
  logic                  w_found;
  logic [PTR_W-1:0]      w_winner;
  logic [PTR_W-1:0]      w_grant_idx;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_grant_data;
  logic [BEAT_W-1:0]     w_beat_inc;

  // Round-robin successor of a port index, wrapping at NUM_REQ.
  function automatic logic [PTR_W-1:0] next_port(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NUM_REQ - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign w_elig     = req_valid & port_enable;
  // The pending registered write is counted as already in the FIFO.
  assign w_occ      = {1'b0, fifo_entry} + (CNT_W+1)'(fifo_wr_enb);
  assign w_room     = w_occ < (CNT_W+1)'(FIFO_DEPTH);
  assign w_beat_inc = r_beat_cnt + BEAT_W'(1);

  // First eligible port searching upward from the round-robin pointer.
  always_comb begin
    logic [PTR_W:0] idx;
    w_found  = 1'b0;
    w_winner = '0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!w_found && w_elig[idx[PTR_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = idx[PTR_W-1:0];
      end
    end
  end

  // Combinational grant: new winner in IDLE, current owner in HOLD.
  always_comb begin
    req_ready   = '0;
    w_grant_idx = (r_state == ST_HOLD) ? active_port : w_winner;
    if (!reset && w_room) begin
      case (r_state)
        ST_IDLE: if (w_found) req_ready[w_winner] = 1'b1;
        ST_HOLD: req_ready[active_port] = w_elig[active_port];
        default: req_ready = '0;
      endcase
    end
  end

  assign w_xfer = |(req_ready & req_valid);

  // Select the data word of the granted port.
  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == PTR_W'(i)) w_grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Arbitration state machine and registered FIFO write path.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
      fifo_wr_enb <= 1'b0;
      fifo_wdata  <= '0;
      active_port <= '0;
      busy        <= 1'b0;
    end else begin
      fifo_wr_enb <= w_xfer;
      if (w_xfer) fifo_wdata <= w_grant_data;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            active_port <= w_winner;
            if (BURST_MAX == 1) begin
              r_state    <= ST_GAP;
              r_rr_ptr   <= next_port(w_winner);
              r_beat_cnt <= '0;
              busy       <= 1'b0;
            end else begin
              r_state    <= ST_HOLD;
              r_beat_cnt <= BEAT_W'(1);
              busy       <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // Owner dropping out or a completed burst both hand over the grant.
          if (!w_elig[active_port] || (w_xfer && w_beat_inc == BEAT_W'(BURST_MAX))) begin
            r_state    <= ST_GAP;
            r_rr_ptr   <= next_port(active_port);
            r_beat_cnt <= '0;
            busy       <= 1'b0;
          end else if (w_xfer) begin
            r_beat_cnt <= w_beat_inc;
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Self-checking bench for fifo_wr_arbiter with a behavioural
//             reference model, directed scenarios and a randomized soak.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int BURST = 4;
  localparam int PW    = 2;
  localparam int CW    = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    port_enable;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [CW-1:0]   fifo_entry;
  logic            fifo_wr_enb;
  logic [DW-1:0]   fifo_wdata;
  logic [PW-1:0]   active_port;
  logic            busy;

  fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BURST_MAX(BURST)
  ) dut (
    .clk(clk), .reset(reset), .port_enable(port_enable), .req_valid(req_valid),
    .req_data(req_data), .req_ready(req_ready), .fifo_entry(fifo_entry),
    .fifo_wr_enb(fifo_wr_enb), .fifo_wdata(fifo_wdata),
    .active_port(active_port), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: owner = -1 when nobody holds the grant.
  int          m_owner, m_beats, m_ptr, m_active;
  bit          m_gap, m_wr, m_busy;
  logic [DW-1:0] m_wdata;

  // Stimulus bookkeeping.
  bit       want [N];
  int       rem  [N];
  int       sent [N];
  logic [3:0] tag [N];
  int       fifo_mode, fixed_entry, occ, drain_pct, valid_pct;
  int       cyc = 0;
  int       gl_cyc[$], gl_port[$];
  int       wl_cyc[$];
  logic [DW-1:0] wl_data[$];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_beats = 0; m_ptr = 0; m_active = 0;
    m_gap = 0; m_wr = 0; m_busy = 0; m_wdata = '0;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      want[i] = 0; rem[i] = 0; sent[i] = 0; tag[i] = 4'(i + 1);
    end
  endtask

  task automatic end_burst();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_beats = 0;
    m_gap   = 1;
  endtask

  // One clock: drive, check model against DUT, advance model at the edge.
  task automatic cycle();
    logic [N-1:0] elig, exp_ready;
    bit room, old_wr, rd;
    int g;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = want[i] && rem[i] > 0 && ($urandom_range(99) < valid_pct);
      req_data[i*DW +: DW] = {tag[i], 12'(sent[i])};
    end
    fifo_entry = (fifo_mode == 0) ? '0 : (fifo_mode == 1) ? CW'(occ) : CW'(fixed_entry);
    #1;
    elig = req_valid & port_enable;
    room = (int'(fifo_entry) + int'(m_wr)) < DEPTH;
    g = -1;
    if (!reset && room) begin
      if (m_owner >= 0) begin
        if (elig[m_owner]) g = m_owner;
      end else if (!m_gap) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && elig[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready",   32'(req_ready),   32'(exp_ready));
    chk("fifo_wr_enb", 32'(fifo_wr_enb), 32'(m_wr));
    chk("fifo_wdata",  32'(fifo_wdata),  32'(m_wdata));
    chk("active_port", 32'(active_port), 32'(m_active));
    chk("busy",        32'(busy),        32'(m_busy));
    if (fifo_wr_enb) begin
      chk("no_overflow", 32'(fifo_entry), 32'(fifo_entry == CW'(DEPTH) ? DEPTH - 1 : int'(fifo_entry)));
      wl_cyc.push_back(cyc);
      wl_data.push_back(fifo_wdata);
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        gl_cyc.push_back(cyc);
        gl_port.push_back(i);
      end
    end
    @(posedge clk);
    old_wr = m_wr;
    if (reset) begin
      model_reset();
    end else begin
      m_wr = (g >= 0);
      if (g >= 0) m_wdata = req_data[g*DW +: DW];
      if (m_owner >= 0) begin
        if (!elig[m_owner]) end_burst();
        else if (g >= 0) begin
          m_beats++;
          if (m_beats == BURST) end_burst();
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else if (g >= 0) begin
        m_active = g; m_owner = g; m_beats = 1;
        if (BURST == 1) end_burst();
      end
      m_busy = (m_owner >= 0);
    end
    if (g >= 0) begin
      rem[g]--;
      sent[g]++;
    end
    rd  = (occ > 0) && ($urandom_range(99) < drain_pct);
    occ = occ + int'(old_wr) - int'(rd);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_stim();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    gl_cyc.delete(); gl_port.delete(); wl_cyc.delete(); wl_data.delete();
  endtask

  initial begin
    int mark;
    int off1[6];
    off1 = '{1, 2, 3, 4, 6, 7};
    reset = 1'b1; port_enable = '1; req_valid = '0; req_data = '0; fifo_entry = '0;
    valid_pct = 100; fifo_mode = 0; fixed_entry = 0; occ = 0; drain_pct = 0;
    model_reset();
    @(negedge clk);

    // Reset state, then a single producer on port 2.
    do_reset();
    chk("reset_wr_enb", 32'(fifo_wr_enb), 32'd0);
    chk("reset_active", 32'(active_port), 32'd0);
    want[2] = 1; rem[2] = 6; tag[2] = 4'hA;
    mark = cyc;
    repeat (10) cycle();
    chk("t1_write_count", 32'(wl_data.size()), 32'd6);
    for (int k = 0; k < 6 && k < wl_data.size(); k++) begin
      chk("t1_wdata", 32'(wl_data[k]), 32'h0000A000 + 32'(k));
      chk("t1_wcycle", 32'(wl_cyc[k] - mark), 32'(off1[k]));
    end
    chk("t1_active", 32'(active_port), 32'd2);

    // All ports valid, FIFO always drained: 0,1,2,3,0 bursts of 4 with a gap.
    do_reset();
    for (int i = 0; i < N; i++) begin want[i] = 1; rem[i] = 100; end
    mark = cyc;
    repeat (24) cycle();
    chk("t2_grant_count", 32'(gl_port.size()), 32'd20);
    for (int k = 0; k < 20 && k < gl_port.size(); k++) begin
      chk("t2_grant_port",  32'(gl_port[k]), 32'((k / 4) % 4));
      chk("t2_grant_cycle", 32'(gl_cyc[k] - mark), 32'(k + k / 4));
    end

    // Nearly full FIFO: one write, then stalled until occupancy drops.
    do_reset();
    want[0] = 1; rem[0] = 100;
    fifo_mode = 2; fixed_entry = 7;
    cycle();
    cycle();
    fixed_entry = 8;
    repeat (3) cycle();
    chk("t3_grants_while_full", 32'(gl_port.size()), 32'd1);
    fixed_entry = 6;
    cycle();
    chk("t3_grant_after_drop", 32'(gl_port.size()), 32'd2);
    fifo_mode = 0;

    // Only ports 1 and 3 enabled.
    do_reset();
    port_enable = 4'b1010;
    for (int i = 0; i < N; i++) begin want[i] = 1; rem[i] = 100; end
    mark = cyc;
    repeat (20) cycle();
    chk("t4_grant_count", 32'(gl_port.size()), 32'd16);
    for (int k = 0; k < 16 && k < gl_port.size(); k++) begin
      chk("t4_grant_port",  32'(gl_port[k]), ((k / 4) % 2 == 1) ? 32'd3 : 32'd1);
      chk("t4_grant_cycle", 32'(gl_cyc[k] - mark), 32'(k + k / 4));
    end
    port_enable = '1;

    // Reset after the second beat of a burst.
    do_reset();
    for (int i = 0; i < N; i++) begin want[i] = 1; rem[i] = 100; end
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("t5_wr_after_reset",   32'(fifo_wr_enb), 32'd0);
    chk("t5_busy_after_reset", 32'(busy),        32'd0);
    gl_port.delete(); gl_cyc.delete();
    cycle();
    chk("t5_restart_count", 32'(gl_port.size()), 32'd1);
    if (gl_port.size() > 0) chk("t5_restart_port", 32'(gl_port[0]), 32'd0);

    // Port 1 drops out after 2 beats; port 2 follows.
    do_reset();
    want[1] = 1; rem[1] = 2;
    want[2] = 1; rem[2] = 100;
    want[3] = 1; rem[3] = 100;
    mark = cyc;
    repeat (6) cycle();
    chk("t6_grant_count", 32'(gl_port.size()), 32'd4);
    if (gl_port.size() >= 3) begin
      chk("t6_first_port",  32'(gl_port[0]), 32'd1);
      chk("t6_next_owner",  32'(gl_port[2]), 32'd2);
      chk("t6_next_cycle",  32'(gl_cyc[2] - mark), 32'd4);
    end

    // Randomized soak with live FIFO occupancy and occasional resets.
    do_reset();
    fifo_mode = 1; occ = 0; valid_pct = 75;
    for (int blk = 0; blk < 40; blk++) begin
      port_enable = N'($urandom_range((1 << N) - 1));
      drain_pct   = $urandom_range(20, 90);
      for (int i = 0; i < N; i++) begin
        want[i] = ($urandom_range(3) != 0);
        rem[i]  = $urandom_range(2, 12);
      end
      for (int c = 0; c < 50; c++) begin
        reset = ($urandom_range(199) == 0);
        cycle();
      end
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
